// File: rtl/dp_ram_pipelined.sv
// True dual-port RAM on a single clock with configurable read latency,
// per-port write modes, byte enables, read-valid tracking and a saturating
// same-address write collision counter. Port A has priority on write overlap.
module dp_ram_pipelined #(
   parameter int unsigned DATA_W       = 256,
   parameter int unsigned ADDR_W       = 16,
   parameter int unsigned LATENCY      = 2,
   parameter int unsigned WRITE_MODE_A = 0,
   parameter int unsigned WRITE_MODE_B = 0,
   parameter int unsigned CNT_W        = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ADDR_W-1:0]   a_addr,
   input  logic [DATA_W-1:0]   a_din,
   input  logic                a_we,
   input  logic [DATA_W/8-1:0] a_be,
   input  logic                a_re,
   output logic [DATA_W-1:0]   a_dout,
   output logic                a_valid,
   input  logic [ADDR_W-1:0]   b_addr,
   input  logic [DATA_W-1:0]   b_din,
   input  logic                b_we,
   input  logic [DATA_W/8-1:0] b_be,
   input  logic                b_re,
   output logic [DATA_W-1:0]   b_dout,
   output logic                b_valid,
   output logic                collision,
   output logic [CNT_W-1:0]    collision_count
);

   localparam int unsigned BYTES            = DATA_W / 8;
   localparam int unsigned DEPTH            = 1 << ADDR_W;
   localparam int unsigned MODE_WRITE_FIRST = 1;
   localparam int unsigned MODE_NO_CHANGE   = 2;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] portAddr  [2];
   logic [DATA_W-1:0] portDin   [2];
   logic              portWe    [2];
   logic [BYTES-1:0]  portBe    [2];
   logic              portRe    [2];
   logic [DATA_W-1:0] portDout  [2];
   logic              portValid [2];

   assign portAddr[0] = a_addr;
   assign portAddr[1] = b_addr;
   assign portDin[0]  = a_din;
   assign portDin[1]  = b_din;
   assign portWe[0]   = a_we;
   assign portWe[1]   = b_we;
   assign portBe[0]   = a_be;
   assign portBe[1]   = b_be;
   assign portRe[0]   = a_re;
   assign portRe[1]   = b_re;

   assign a_dout  = portDout[0];
   assign a_valid = portValid[0];
   assign b_dout  = portDout[1];
   assign b_valid = portValid[1];

   // Byte-masked writes; port A is applied last so it wins overlapping bytes
   always_ff @(posedge clk) begin
      for (int i = 0; i < BYTES; i++) begin
         if (b_we && b_be[i]) mem[b_addr][8*i +: 8] <= b_din[8*i +: 8];
         if (a_we && a_be[i]) mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
      end
   end

   for (genvar p = 0; p < 2; p++) begin : gPort
      localparam int unsigned MODE = (p == 0) ? WRITE_MODE_A : WRITE_MODE_B;

      logic [DATA_W-1:0] oldWord;
      logic [DATA_W-1:0] mergedWord;
      logic [DATA_W-1:0] rdData;
      logic              capture;
      logic [DATA_W-1:0] doutQ;
      logic              validQ;

      // Select read data by write mode; NO_CHANGE suppresses the data load
      always_comb begin
         oldWord    = mem[portAddr[p]];
         mergedWord = oldWord;
         rdData     = oldWord;
         capture    = portRe[p];
         for (int i = 0; i < BYTES; i++) begin
            if (portBe[p][i]) mergedWord[8*i +: 8] = portDin[p][8*i +: 8];
         end
         if (portWe[p]) begin
            if (MODE == MODE_WRITE_FIRST) rdData = mergedWord;
            else if (MODE == MODE_NO_CHANGE) capture = 1'b0;
         end
      end

      if (LATENCY == 1) begin : gLat1
         // Single-stage read: dout/valid update on the sampling edge
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               doutQ  <= '0;
               validQ <= 1'b0;
            end else begin
               validQ <= portRe[p];
               if (capture) doutQ <= rdData;
            end
         end
      end else begin : gLat2
         logic [DATA_W-1:0] s1Data;
         logic              s1Valid;
         logic              s1Load;

         // First read stage, advances every clock
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               s1Data  <= '0;
               s1Valid <= 1'b0;
               s1Load  <= 1'b0;
            end else begin
               s1Valid <= portRe[p];
               s1Load  <= capture;
               if (capture) s1Data <= rdData;
            end
         end

         // Output register stage
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               doutQ  <= '0;
               validQ <= 1'b0;
            end else begin
               validQ <= s1Valid;
               if (s1Load) doutQ <= s1Data;
            end
         end
      end

      assign portDout[p]  = doutQ;
      assign portValid[p] = validQ;
   end

   logic sameAddrWrite;
   assign sameAddrWrite = a_we && b_we && (a_addr == b_addr);

   // Collision pulse and saturating collision counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         collision       <= 1'b0;
         collision_count <= '0;
      end else begin
         collision <= sameAddrWrite;
         if (sameAddrWrite && (collision_count != '1)) begin
            collision_count <= collision_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_dp_ram_pipelined.sv
// Directed bench for dp_ram_pipelined. Four instances share the stimulus:
// 0 = LATENCY 2 READ_FIRST, 1 = LATENCY 2 WRITE_FIRST on A,
// 2 = LATENCY 2 NO_CHANGE on A, 3 = LATENCY 1 READ_FIRST.
module tb_dp_ram_pipelined;

   logic        clk;
   logic        resetN;
   logic [3:0]  aAddr, bAddr;
   logic [31:0] aDin, bDin;
   logic        aWe, bWe, aRe, bRe;
   logic [3:0]  aBe, bBe;

   logic [31:0] aDout [4];
   logic [31:0] bDout [4];
   logic        aValid [4];
   logic        bValid [4];
   logic        coll [4];
   logic [1:0]  collCount [4];

   int checks   = 0;
   int failures = 0;

   for (genvar g = 0; g < 4; g++) begin : gDut
      dp_ram_pipelined #(
         .DATA_W       (32),
         .ADDR_W       (4),
         .LATENCY      ((g == 3) ? 1 : 2),
         .WRITE_MODE_A ((g == 1) ? 1 : ((g == 2) ? 2 : 0)),
         .WRITE_MODE_B (0),
         .CNT_W        (2)
      ) uDut (
         .clk             (clk),
         .reset_n         (resetN),
         .a_addr          (aAddr),
         .a_din           (aDin),
         .a_we            (aWe),
         .a_be            (aBe),
         .a_re            (aRe),
         .a_dout          (aDout[g]),
         .a_valid         (aValid[g]),
         .b_addr          (bAddr),
         .b_din           (bDin),
         .b_we            (bWe),
         .b_be            (bBe),
         .b_re            (bRe),
         .b_dout          (bDout[g]),
         .b_valid         (bValid[g]),
         .collision       (coll[g]),
         .collision_count (collCount[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      aWe = 0; bWe = 0; aRe = 0; bRe = 0;
      aBe = 4'h0; bBe = 4'h0;
   endtask

   task automatic writeA(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
      idle();
      aWe = 1; aAddr = addr; aDin = data; aBe = be;
      tick();
      idle();
   endtask

   task automatic test_reset();
      for (int g = 0; g < 4; g++) begin
         checks++;
         if (aDout[g] !== 32'h0 || bDout[g] !== 32'h0 || aValid[g] !== 1'b0 || bValid[g] !== 1'b0
             || coll[g] !== 1'b0 || collCount[g] !== 2'd0) begin
            failures++;
            $display("FAIL reset inst%0d got aDout=%h bDout=%h aV=%b bV=%b coll=%b cnt=%0d want all zero",
                     g, aDout[g], bDout[g], aValid[g], bValid[g], coll[g], collCount[g]);
         end
      end
   endtask

   task automatic test_write_read();
      writeA(4'd3, 32'hDEADBEEF, 4'hF);
      bRe = 1; bAddr = 4'd3;
      tick();
      bRe = 0;
      checks++;
      if (bValid[3] !== 1'b1 || bDout[3] !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL lat1_read got v=%b d=%h want v=1 d=deadbeef", bValid[3], bDout[3]);
      end
      checks++;
      if (bValid[0] !== 1'b0) begin
         failures++;
         $display("FAIL lat2_early_valid got %b want 0", bValid[0]);
      end
      tick();
      checks++;
      if (bValid[0] !== 1'b1 || bDout[0] !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL lat2_read got v=%b d=%h want v=1 d=deadbeef", bValid[0], bDout[0]);
      end
      checks++;
      if (bValid[3] !== 1'b0 || bDout[3] !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL lat1_hold got v=%b d=%h want v=0 d=deadbeef", bValid[3], bDout[3]);
      end
      tick();
      checks++;
      if (bValid[0] !== 1'b0) begin
         failures++;
         $display("FAIL lat2_single_valid got %b want 0", bValid[0]);
      end
   endtask

   task automatic test_byte_enable();
      writeA(4'd5, 32'h11223344, 4'hF);
      writeA(4'd5, 32'hAABBCCDD, 4'h5);
      writeA(4'd5, 32'hFFFFFFFF, 4'h0);
      aRe = 1; aAddr = 4'd5;
      tick();
      aRe = 0;
      tick();
      checks++;
      if (aValid[0] !== 1'b1 || aDout[0] !== 32'h11BB33DD) begin
         failures++;
         $display("FAIL byte_enable got v=%b d=%h want v=1 d=11bb33dd", aValid[0], aDout[0]);
      end
   endtask

   task automatic test_write_modes();
      writeA(4'd7, 32'h0, 4'hF);
      aRe = 1; aWe = 1; aAddr = 4'd7; aDin = 32'h55; aBe = 4'hF;
      tick();
      idle();
      checks++;
      if (aValid[3] !== 1'b1 || aDout[3] !== 32'h0) begin
         failures++;
         $display("FAIL lat1_read_first got v=%b d=%h want v=1 d=0", aValid[3], aDout[3]);
      end
      tick();
      checks++;
      if (aValid[0] !== 1'b1 || aDout[0] !== 32'h0) begin
         failures++;
         $display("FAIL read_first got v=%b d=%h want v=1 d=0", aValid[0], aDout[0]);
      end
      checks++;
      if (aValid[1] !== 1'b1 || aDout[1] !== 32'h55) begin
         failures++;
         $display("FAIL write_first got v=%b d=%h want v=1 d=55", aValid[1], aDout[1]);
      end
      checks++;
      if (aValid[2] !== 1'b1 || aDout[2] !== 32'h11BB33DD) begin
         failures++;
         $display("FAIL no_change got v=%b d=%h want v=1 d=11bb33dd", aValid[2], aDout[2]);
      end
   endtask

   task automatic test_collision();
      for (int n = 1; n <= 5; n++) begin
         aWe = 1; aAddr = 4'd9; aDin = 32'h000000AA; aBe = 4'h1;
         bWe = 1; bAddr = 4'd9; bDin = 32'hBBBBBBBB; bBe = 4'hF;
         tick();
         idle();
         if (n == 1) begin
            checks++;
            if (coll[0] !== 1'b1 || collCount[0] !== 2'd1) begin
               failures++;
               $display("FAIL collision_pulse got coll=%b cnt=%0d want coll=1 cnt=1", coll[0], collCount[0]);
            end
         end
         tick();
         if (n == 1) begin
            checks++;
            if (coll[0] !== 1'b0) begin
               failures++;
               $display("FAIL collision_one_cycle got %b want 0", coll[0]);
            end
         end
      end
      checks++;
      if (collCount[0] !== 2'd3) begin
         failures++;
         $display("FAIL collision_saturate got %0d want 3", collCount[0]);
      end
      aRe = 1; aAddr = 4'd9;
      tick();
      aRe = 0;
      tick();
      checks++;
      if (aDout[0] !== 32'hBBBBBBAA) begin
         failures++;
         $display("FAIL collision_merge got %h want bbbbbbaa", aDout[0]);
      end
      // Independent writes to different addresses on both ports
      aWe = 1; aAddr = 4'd10; aDin = 32'h0A0A0A0A; aBe = 4'hF;
      bWe = 1; bAddr = 4'd11; bDin = 32'h0B0B0B0B; bBe = 4'hF;
      tick();
      idle();
      checks++;
      if (coll[0] !== 1'b0 || collCount[0] !== 2'd3) begin
         failures++;
         $display("FAIL no_collision got coll=%b cnt=%0d want coll=0 cnt=3", coll[0], collCount[0]);
      end
      aRe = 1; aAddr = 4'd10; bRe = 1; bAddr = 4'd11;
      tick();
      idle();
      tick();
      checks++;
      if (aDout[0] !== 32'h0A0A0A0A || bDout[0] !== 32'h0B0B0B0B) begin
         failures++;
         $display("FAIL independent_writes got a=%h b=%h want a=0a0a0a0a b=0b0b0b0b", aDout[0], bDout[0]);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp;
      for (int i = 0; i < 4; i++) writeA(4'(i), 32'hA0 + 32'(i), 4'hF);
      for (int k = 0; k <= 5; k++) begin
         bRe = (k < 4); bAddr = 4'(k);
         tick();
         if (k >= 1 && k <= 4) begin
            exp = 32'hA0 + 32'(k - 1);
            checks++;
            if (bValid[0] !== 1'b1 || bDout[0] !== exp) begin
               failures++;
               $display("FAIL stream_%0d got v=%b d=%h want v=1 d=%h", k - 1, bValid[0], bDout[0], exp);
            end
         end
      end
      checks++;
      if (bValid[0] !== 1'b0 || bDout[0] !== 32'hA3) begin
         failures++;
         $display("FAIL stream_idle got v=%b d=%h want v=0 d=a3", bValid[0], bDout[0]);
      end
   endtask

   task automatic test_reset_midstream();
      bRe = 1; bAddr = 4'd0;
      tick();
      bAddr = 4'd1;
      tick();
      bRe = 0;
      resetN = 0;
      #1;
      checks++;
      if (bValid[0] !== 1'b0 || bDout[0] !== 32'h0 || bDout[3] !== 32'h0 || collCount[0] !== 2'd0) begin
         failures++;
         $display("FAIL async_reset got v=%b d=%h d1=%h cnt=%0d want zeros",
                  bValid[0], bDout[0], bDout[3], collCount[0]);
      end
      tick();
      #2;
      resetN = 1;
      tick();
      checks++;
      if (bValid[0] !== 1'b0 || bValid[3] !== 1'b0) begin
         failures++;
         $display("FAIL dropped_read got v2=%b v1=%b want 0", bValid[0], bValid[3]);
      end
      bRe = 1; bAddr = 4'd1;
      tick();
      bRe = 0;
      tick();
      checks++;
      if (bValid[0] !== 1'b1 || bDout[0] !== 32'hA1) begin
         failures++;
         $display("FAIL mem_retained got v=%b d=%h want v=1 d=a1", bValid[0], bDout[0]);
      end
   endtask

   task automatic test_cross_port();
      aWe = 1; aAddr = 4'd3; aDin = 32'h33333333; aBe = 4'hF;
      bRe = 1; bAddr = 4'd3;
      tick();
      idle();
      checks++;
      if (bValid[3] !== 1'b1 || bDout[3] !== 32'hA3) begin
         failures++;
         $display("FAIL cross_port_lat1 got v=%b d=%h want v=1 d=a3", bValid[3], bDout[3]);
      end
      tick();
      checks++;
      if (bDout[0] !== 32'hA3 || bDout[1] !== 32'hA3) begin
         failures++;
         $display("FAIL cross_port_lat2 got rf=%h wf=%h want a3", bDout[0], bDout[1]);
      end
      bRe = 1; bAddr = 4'd3;
      tick();
      idle();
      checks++;
      if (bDout[3] !== 32'h33333333) begin
         failures++;
         $display("FAIL cross_port_new got %h want 33333333", bDout[3]);
      end
   endtask

   initial begin
      resetN = 0;
      aAddr = '0; bAddr = '0; aDin = '0; bDin = '0;
      idle();
      tick();
      tick();
      test_reset();
      resetN = 1;
      tick();
      test_write_read();
      test_byte_enable();
      test_write_modes();
      test_collision();
      test_back_to_back();
      test_reset_midstream();
      test_cross_port();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
